// File: rtl/interp_feed_ctrl.sv
// interp_feed_ctrl: frame-aligned sample feed with priming and underrun/overrun status
// Define FEED_SOFT_MUTE_EN to ramp v_out toward zero on every frame spent in underrun.
module interp_feed_ctrl #(
    parameter int FRAME_LEN   = 8,
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 4,
    parameter int DATA_W      = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          v_out,
    output logic                       frame_tick,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [1:0]                 state_o,
    output logic                       underrun,
    output logic                       overrun,
    input  logic                       err_clear,
    output logic [15:0]                underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDER} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       phase;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   v_ramp;
    logic                full, empty, primed, edge_f, push, pop, starve, mute_step;

    assign full       = count == (AW+1)'(DEPTH);
    assign empty      = count == '0;
    assign primed     = count >= (AW+1)'(PRIME_LEVEL);
    assign edge_f     = phase == PW'(FRAME_LEN-1);
    assign frame_tick = edge_f && !reset;
    assign in_ready   = !full && enable && !reset;
    assign push       = in_valid && in_ready;
    assign fill_level = count;
    assign state_o    = state;

`ifdef FEED_SOFT_MUTE_EN
    logic signed [DATA_W-1:0] v_s;
    assign v_s    = v_out;
    assign v_ramp = (int'(v_s) > -4 && int'(v_s) < 4) ? '0 : v_s - (v_s >>> 2);
`else
    assign v_ramp = v_out;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // PRIME and UNDER share the same exit rule: wait for a full prime level at a frame edge.
    always_comb begin
        state_nx = !enable ? IDLE :
                   state == IDLE ? PRIME :
                   !edge_f ? state :
                   state == RUN ? (empty ? UNDER : RUN) :
                   primed ? RUN : state;
    end

    always_comb begin
        pop       = enable && edge_f && (state == RUN ? !empty : (state == PRIME || state == UNDER) && primed);
        starve    = enable && edge_f && empty && (state == RUN || state == UNDER);
        mute_step = enable && edge_f && state == UNDER && !pop;
    end

    always_ff @(posedge clock) begin
        if (reset) phase <= '0;
        else phase <= edge_f ? '0 : phase + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) v_out <= '0;
        else if (pop) v_out <= mem[rd_ptr];
        else if (mute_step) v_out <= v_ramp;
    end

    // A set event in the same cycle as err_clear takes priority over the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            overrun      <= (in_valid && enable && full) ? 1'b1 : err_clear ? 1'b0 : overrun;
            underrun     <= starve ? 1'b1 : err_clear ? 1'b0 : underrun;
            underrun_cnt <= starve ? (err_clear ? 16'd1 : (&underrun_cnt ? underrun_cnt : underrun_cnt + 16'd1)) :
                            err_clear ? '0 : underrun_cnt;
        end
    end
endmodule
